// File: rtl/mem_stage_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_sram_ctrl_pkg
//  Description : Shared constants and types for the MEM-stage SRAM controller.
//                Holds the FSM state encoding, the default byte address that
//                maps to SRAM word 0, and the external SRAM bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_sram_ctrl_pkg;

  // Access sequencer states: low half-word, then high half-word, then a
  // single-cycle completion pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] c_addr_base_default = 32'd1024;

  localparam int c_sram_data_w = 16;
  localparam int c_sram_addr_w = 18;
  localparam int c_cnt_w       = 4;

endpackage : mem_stage_sram_ctrl_pkg
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_sram_ctrl
//  Description : Memory stage front end for a 16-bit asynchronous SRAM.
//                Performs each 32-bit load/store as two half-word accesses
//                (low half first), each held on the bus for HALF_CYCLES clocks,
//                and freezes the pipeline through `ready` while busy.
//
//  Ports:
//    clk, rst      - pipeline clock, synchronous active-high reset
//    wr_en, rd_en  - store / load request from EXE/MEM (store wins if both)
//    address       - byte address (ALU result), bits [1:0] ignored
//    write_data    - store data (Val_Rm)
//    read_data     - load result, valid when `ready` rises after a load
//    ready         - 0 freezes the pipeline
//    sram_addr     - SRAM half-word address
//    sram_dq_out   - write data towards the SRAM
//    sram_dq_in    - read data from the SRAM
//    sram_dq_oe    - 1 = drive sram_dq_out onto the shared data bus
//    sram_we_n     - SRAM write enable, active-low
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = c_addr_base_default,
  parameter int          HALF_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  output logic [c_sram_addr_w-1:0] sram_addr,
  output logic [c_sram_data_w-1:0] sram_dq_out,
  input  logic [c_sram_data_w-1:0] sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n
);

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(HALF_CYCLES - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [c_cnt_w-1:0]       w_cnt_nxt;
  logic                     r_is_wr;
  logic                     w_is_wr_nxt;
  logic [c_sram_data_w-1:0] r_lo_buf;
  logic [31:0]              r_read_data;

  logic                     w_req;
  logic                     w_last;
  logic                     w_lo_cap;
  logic                     w_hi_cap;
  logic [31:0]              w_off;
  logic                     w_unused_off_bits;

  assign w_req  = wr_en | rd_en;
  assign w_last = (r_cnt == c_cnt_last);

  // The frozen pipeline keeps address stable, so the offset is recomputed
  // every cycle instead of being latched at request time.
  assign w_off = address - ADDR_BASE;

  // Only bits [18:2] address the SRAM; the rest wrap silently.
  assign w_unused_off_bits = ^{w_off[31:19], w_off[1:0]};

  // Freeze asserts combinationally in the very cycle a request appears.
  assign ready     = ~w_req | (r_state == DONE);
  assign read_data = r_read_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_is_wr     <= 1'b0;
      r_lo_buf    <= '0;
      r_read_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_is_wr <= w_is_wr_nxt;
      if (w_lo_cap) begin
        r_lo_buf <= sram_dq_in;
      end
      if (w_hi_cap) begin
        r_read_data <= {sram_dq_in, r_lo_buf};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_is_wr_nxt = r_is_wr;
    w_lo_cap    = 1'b0;
    w_hi_cap    = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_is_wr_nxt = wr_en;
          w_cnt_nxt   = '0;
          w_state_nxt = LO;
        end
      end

      LO: begin
        sram_addr = {w_off[18:2], 1'b0};
        if (r_is_wr) begin
          sram_dq_out = write_data[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        // A dropped request (flush/branch) abandons the access; any half
        // already written stays written.
        if (!w_req) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_lo_cap    = ~r_is_wr;
          w_cnt_nxt   = '0;
          w_state_nxt = HI;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      HI: begin
        sram_addr = {w_off[18:2], 1'b1};
        if (r_is_wr) begin
          sram_dq_out = write_data[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (!w_req) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_hi_cap    = ~r_is_wr;
          w_cnt_nxt   = '0;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      DONE: begin
        // Pipeline advances on this edge; a following request passes
        // through IDLE before re-entering LO.
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule : mem_stage_sram_ctrl
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_sram_ctrl
//  Description : Self-checking bench for mem_stage_sram_ctrl with a small
//                behavioural SRAM and a load-result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram_ctrl;

  localparam int HALF = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  // Behavioural SRAM (low 256 half-words), combinational read.
  logic [15:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr[7:0]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
  end

  mem_stage_sram_ctrl #(
    .ADDR_BASE   (32'd1024),
    .HALF_CYCLES (HALF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drop_req();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Counts freeze cycles from the current cycle up to the ready cycle, and
  // pops the scoreboard when a load completes.
  task automatic wait_done(input logic is_rd, output int low, output int we_low,
                           output logic [17:0] addr_lo, output logic [17:0] addr_hi);
    logic [31:0] exp;
    logic        done;
    low = 0; we_low = 0; addr_lo = '1; addr_hi = '1; done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (ready) begin
        done = 1'b1;
        break;
      end
      if (low == 1)        addr_lo = sram_addr;
      if (low == 1 + HALF) addr_hi = sram_addr;
      if (!sram_we_n) we_low++;
      low++;
      @(negedge clk);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: ready still %0b, required 1 within 64 cycles", ready);
    end
    if (done && is_rd) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: load completed with read_data %h, required no pending load", read_data);
      end else begin
        exp = exp_q.pop_front();
        if (read_data !== exp) begin
          n_fail++;
          $display("FAIL load_data: read_data %h, required %h", read_data, exp);
        end
      end
    end
  endtask

  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, output int low, output int we_low,
                        output logic [17:0] addr_lo, output logic [17:0] addr_hi);
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    wait_done(rd & ~wr, low, we_low, addr_lo, addr_hi);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (ready !== 1'b1)      begin n_fail++; $display("FAIL rst_ready: %b, required 1", ready); end
    n_checks++; if (sram_we_n !== 1'b1)  begin n_fail++; $display("FAIL rst_we_n: %b, required 1", sram_we_n); end
    n_checks++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: %b, required 0", sram_dq_oe); end
    n_checks++; if (sram_addr !== 18'd0) begin n_fail++; $display("FAIL rst_addr: %h, required 0", sram_addr); end
    n_checks++; if (sram_dq_out !== 16'd0) begin n_fail++; $display("FAIL rst_dq_out: %h, required 0", sram_dq_out); end
    n_checks++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL rst_read_data: %h, required 0", read_data); end
  endtask

  task automatic test_store_load();
    int low, we_low;
    logic [17:0] alo, ahi;
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, low, we_low, alo, ahi);
    n_checks++; if (low != 7)    begin n_fail++; $display("FAIL store_freeze: %0d cycles, required 7", low); end
    n_checks++; if (we_low != 6) begin n_fail++; $display("FAIL store_we_low: %0d cycles, required 6", we_low); end
    n_checks++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL store_rd_kept: %h, required 0", read_data); end
    drop_req();
    n_checks++; if (mem[0] !== 16'hBEEF) begin n_fail++; $display("FAIL store_lo: mem[0] %h, required beef", mem[0]); end
    n_checks++; if (mem[1] !== 16'hDEAD) begin n_fail++; $display("FAIL store_hi: mem[1] %h, required dead", mem[1]); end
    exp_q.push_back(32'hDEADBEEF);
    access(1'b0, 1'b1, 32'd1024, 32'h0, low, we_low, alo, ahi);
    n_checks++; if (low != 7)    begin n_fail++; $display("FAIL load_freeze: %0d cycles, required 7", low); end
    n_checks++; if (we_low != 0) begin n_fail++; $display("FAIL load_we_low: %0d cycles, required 0", we_low); end
    drop_req();
  endtask

  task automatic test_addr_map();
    int low, we_low;
    logic [17:0] alo, ahi;
    poke(8'd4, 16'h1234);
    poke(8'd5, 16'hABCD);
    exp_q.push_back(32'hABCD1234);
    access(1'b0, 1'b1, 32'd1032, 32'h0, low, we_low, alo, ahi);
    n_checks++; if (alo !== 18'd4) begin n_fail++; $display("FAIL map_lo_addr: %0d, required 4", alo); end
    n_checks++; if (ahi !== 18'd5) begin n_fail++; $display("FAIL map_hi_addr: %0d, required 5", ahi); end
    drop_req();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || read_data !== 32'hABCD1234) begin
        n_fail++;
        $display("FAIL idle[%0d]: ready=%b we_n=%b oe=%b rd=%h, required 1 1 0 abcd1234",
                 i, ready, sram_we_n, sram_dq_oe, read_data);
      end
    end
  endtask

  task automatic test_flush_write();
    poke(8'd8, 16'h0000);
    poke(8'd9, 16'h0000);
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; write_data = 32'h11112222;
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (sram_addr !== 18'd9) begin n_fail++; $display("FAIL flush_in_hi: addr %0d, required 9", sram_addr); end
    wr_en = 1'b0;
    #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: %b, required 1", ready); end
    @(negedge clk); #1;
    n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL flush_we_n: %b, required 1", sram_we_n); end
    n_checks++; if (sram_addr !== 18'd0) begin n_fail++; $display("FAIL flush_idle_addr: %0d, required 0", sram_addr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_quiet[%0d]: ready=%b we_n=%b oe=%b, required 1 1 0", i, ready, sram_we_n, sram_dq_oe);
      end
    end
    n_checks++; if (mem[8] !== 16'h2222) begin n_fail++; $display("FAIL flush_lo_written: mem[8] %h, required 2222", mem[8]); end
  endtask

  task automatic test_reset_mid_read();
    int low, we_low;
    logic [17:0] alo, ahi;
    poke(8'd2, 16'h5555);
    poke(8'd3, 16'h6666);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; address = 32'd1028; write_data = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_rd: %h, required 0", read_data); end
    n_checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_bus: we_n=%b oe=%b, required 1 0", sram_we_n, sram_dq_oe); end
    n_checks++; if (sram_addr !== 18'd0) begin n_fail++; $display("FAIL rstmid_addr: %0d, required 0", sram_addr); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: %b, required 0", ready); end
    rst = 1'b0;
    exp_q.push_back(32'h66665555);
    wait_done(1'b1, low, we_low, alo, ahi);
    n_checks++; if (low != 7) begin n_fail++; $display("FAIL rstmid_restart: %0d cycles, required 7", low); end
    n_checks++; if (alo !== 18'd2) begin n_fail++; $display("FAIL rstmid_lo_addr: %0d, required 2", alo); end
    drop_req();
  endtask

  task automatic test_simultaneous();
    int low, we_low;
    logic [17:0] alo, ahi;
    access(1'b1, 1'b1, 32'd1024, 32'h00000005, low, we_low, alo, ahi);
    n_checks++; if (we_low != 6) begin n_fail++; $display("FAIL both_we_low: %0d, required 6", we_low); end
    n_checks++; if (read_data !== 32'h66665555) begin n_fail++; $display("FAIL both_rd_kept: %h, required 66665555", read_data); end
    drop_req();
    n_checks++; if (mem[0] !== 16'h0005) begin n_fail++; $display("FAIL both_lo: mem[0] %h, required 0005", mem[0]); end
    n_checks++; if (mem[1] !== 16'h0000) begin n_fail++; $display("FAIL both_hi: mem[1] %h, required 0000", mem[1]); end
  endtask

  task automatic test_back_to_back();
    int low, we_low;
    logic [17:0] alo, ahi;
    exp_q.push_back(32'h00000005);
    access(1'b0, 1'b1, 32'd1024, 32'h0, low, we_low, alo, ahi);
    n_checks++; if (low != 7) begin n_fail++; $display("FAIL b2b_first: %0d cycles, required 7", low); end
    exp_q.push_back(32'hABCD1234);
    access(1'b0, 1'b1, 32'd1032, 32'h0, low, we_low, alo, ahi);
    n_checks++; if (low != 7) begin n_fail++; $display("FAIL b2b_second: %0d cycles, required 7", low); end
    n_checks++; if (alo !== 18'd4) begin n_fail++; $display("FAIL b2b_lo_addr: %0d, required 4", alo); end
    drop_req();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    pre_en = 1'b0; pre_addr = 8'd0; pre_data = 16'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_store_load();
    test_addr_map();
    test_idle();
    test_flush_write();
    test_reset_mid_read();
    test_simultaneous();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_stage_sram_ctrl
`default_nettype wire
